// File: rtl/gl_decode_pkg.sv
// Shared constants, opcode table and state encoding for the decode stage.
// The opcode -> operand-count lookup lives here so the RTL and any checker share one table.
package gl_decode_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_MAX_OPS = 16;
  localparam int NOPS_W      = 5;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_CTRL_01    = 8'h01;
  localparam logic [7:0] OP_CTRL_02    = 8'h02;
  localparam logic [7:0] OP_VERTEX     = 8'h03;
  localparam logic [7:0] OP_COLOR      = 8'h04;
  localparam logic [7:0] OP_MULTMATRIX = 8'h11;
  localparam logic [7:0] OP_LOADMATRIX = 8'h13;
  localparam logic [7:0] OP_ROTATE     = 8'h16;
  localparam logic [7:0] OP_SCALE      = 8'h17;
  localparam logic [7:0] OP_TRANSLATE  = 8'h18;
  localparam logic [7:0] OP_VIEWPORT   = 8'h19;
  localparam logic [7:0] OP_FRUSTUM    = 8'h1A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [NOPS_W-1:0] nops;
    logic              is_nop;
    logic              err;
  } op_info_t;

  function automatic op_info_t op_lookup(input logic [7:0] opcode);
    op_info_t info;
    info.nops   = '0;
    info.is_nop = 1'b0;
    info.err    = 1'b0;
    case (opcode)
      OP_NOP:                 info.is_nop = 1'b1;
      OP_CTRL_01, OP_CTRL_02: info.nops = 5'd0;
      OP_VERTEX, OP_COLOR:    info.nops = 5'd3;
      OP_MULTMATRIX, OP_LOADMATRIX, OP_ROTATE,
      OP_SCALE, OP_TRANSLATE: info.nops = 5'd16;
      OP_VIEWPORT:            info.nops = 5'd4;
      OP_FRUSTUM:             info.nops = 5'd6;
      default:                info.err = 1'b1;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/gl_opcode_len.sv
// Combinational opcode classifier: operand count, NOP flag and unknown-opcode flag.
module gl_opcode_len
  import gl_decode_pkg::*;
(
  input  logic [7:0]        opcode,
  output logic [NOPS_W-1:0] nops,
  output logic              is_nop,
  output logic              err
);

  op_info_t info;

  always_comb begin
    info   = op_lookup(opcode);
    nops   = info.nops;
    is_nop = info.is_nop;
    err    = info.err;
  end

endmodule

// File: rtl/gl_decode.sv
// Decode stage: accepts one opcode from fetch, gathers its operands from the instruction
// BRAM and presents opcode + operands as a single packet to the transform/raster stages.
module gl_decode
  import gl_decode_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_OPS = DEF_MAX_OPS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         inst_in,
  input  logic                     inst_valid,
  input  logic [WIDTH-1:0]         op_base_addr,
  output logic                     stall,
  output logic [WIDTH-1:0]         bram_addr,
  output logic                     bram_en,
  input  logic [WIDTH-1:0]         bram_data,
  output logic                     pkt_valid,
  input  logic                     pkt_ready,
  output logic [7:0]               pkt_opcode,
  output logic [NOPS_W-1:0]        pkt_nops,
  output logic [WIDTH*MAX_OPS-1:0] pkt_ops,
  output logic                     pkt_err,
  output logic [1:0]               dbg_state
);

  // Handshake: a packet transfers on a rising edge where pkt_valid & pkt_ready; once
  // pkt_valid rises every pkt_* output is held until that edge. pkt_ready is ignored
  // while pkt_valid is low. Fetch is held off by stall, which has no ready counterpart.

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      base_q, base_d;
  logic [NOPS_W-1:0]     rd_idx_q, rd_idx_d;
  logic [NOPS_W-1:0]     wr_idx_q, wr_idx_d;
  logic [7:0]            opcode_q, opcode_d;
  logic [NOPS_W-1:0]     nops_q, nops_d;
  logic                  err_q, err_d;
  logic                  pkt_valid_q, pkt_valid_d;
  logic [WIDTH-1:0]      ops_q [MAX_OPS];
  logic [WIDTH-1:0]      ops_d [MAX_OPS];

  logic [NOPS_W-1:0]     in_nops;
  logic                  in_is_nop;
  logic                  in_err;
  logic                  accept;
  logic                  unused_inst_hi;

  gl_opcode_len u_opcode_len (
    .opcode (inst_in[7:0]),
    .nops   (in_nops),
    .is_nop (in_is_nop),
    .err    (in_err)
  );

  // Only the low byte carries the opcode; the rest of the fetch word is don't-care here.
  assign unused_inst_hi = ^inst_in[WIDTH-1:8];

  assign accept = inst_valid & ~in_is_nop;
  assign stall  = (state_q != ST_IDLE) | accept;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q;
    opcode_d    = opcode_q;
    nops_d      = nops_q;
    err_d       = err_q;
    pkt_valid_d = pkt_valid_q;
    ops_d       = ops_q;
    bram_en     = 1'b0;
    bram_addr   = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          opcode_d = inst_in[7:0];
          nops_d   = in_nops;
          err_d    = in_err;
          base_d   = op_base_addr;
          wr_idx_d = '0;
          rd_idx_d = '0;
          for (int k = 0; k < MAX_OPS; k++) ops_d[k] = '0;
          if (in_nops == '0) begin
            pkt_valid_d = 1'b1;
            state_d     = ST_OUT;
          end else begin
            // First read issues in the accept cycle so data lands while entering READ.
            bram_en   = 1'b1;
            bram_addr = op_base_addr;
            rd_idx_d  = NOPS_W'(1);
            state_d   = (in_nops == NOPS_W'(1)) ? ST_DRAIN : ST_READ;
          end
        end
      end

      ST_READ: begin
        bram_en   = 1'b1;
        bram_addr = base_q + WIDTH'(rd_idx_q);
        rd_idx_d  = rd_idx_q + NOPS_W'(1);
        for (int k = 0; k < MAX_OPS; k++) begin
          if (wr_idx_q == NOPS_W'(k)) ops_d[k] = bram_data;
        end
        wr_idx_d = wr_idx_q + NOPS_W'(1);
        if (rd_idx_d == nops_q) state_d = ST_DRAIN;
      end

      ST_DRAIN: begin
        for (int k = 0; k < MAX_OPS; k++) begin
          if (wr_idx_q == NOPS_W'(k)) ops_d[k] = bram_data;
        end
        wr_idx_d    = wr_idx_q + NOPS_W'(1);
        pkt_valid_d = 1'b1;
        state_d     = ST_OUT;
      end

      ST_OUT: begin
        if (pkt_ready) begin
          pkt_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
      opcode_q    <= '0;
      nops_q      <= '0;
      err_q       <= 1'b0;
      pkt_valid_q <= 1'b0;
      for (int k = 0; k < MAX_OPS; k++) ops_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      opcode_q    <= opcode_d;
      nops_q      <= nops_d;
      err_q       <= err_d;
      pkt_valid_q <= pkt_valid_d;
      for (int k = 0; k < MAX_OPS; k++) ops_q[k] <= ops_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < MAX_OPS; k++) pkt_ops[k*WIDTH +: WIDTH] = ops_q[k];
  end

  assign pkt_valid  = pkt_valid_q;
  assign pkt_opcode = opcode_q;
  assign pkt_nops   = nops_q;
  assign pkt_err    = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_gl_decode.sv
// Directed bench for gl_decode: behavioural BRAM, address scoreboard, hand-computed packets.
module tb_gl_decode;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  inst_in;
  logic         inst_valid;
  logic [31:0]  op_base_addr;
  logic         stall;
  logic [31:0]  bram_addr;
  logic         bram_en;
  logic [31:0]  bram_data;
  logic         pkt_valid;
  logic         pkt_ready;
  logic [7:0]   pkt_opcode;
  logic [4:0]   pkt_nops;
  logic [511:0] pkt_ops;
  logic         pkt_err;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] seen_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_ops [16];

  gl_decode dut (
    .clk          (clk),
    .reset        (reset),
    .inst_in      (inst_in),
    .inst_valid   (inst_valid),
    .op_base_addr (op_base_addr),
    .stall        (stall),
    .bram_addr    (bram_addr),
    .bram_en      (bram_en),
    .bram_data    (bram_data),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_opcode   (pkt_opcode),
    .pkt_nops     (pkt_nops),
    .pkt_ops      (pkt_ops),
    .pkt_err      (pkt_err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // BRAM model: one-cycle read latency, logs every enabled address
  always @(posedge clk) begin
    if (bram_en) begin
      bram_data <= mem.exists(bram_addr) ? mem[bram_addr] : 32'hBAD0BAD0;
      seen_q.push_back(bram_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic prep();
    seen_q.delete();
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_ops[k] = '0;
  endtask

  task automatic load(input logic [31:0] base, input int n, input logic [31:0] first,
                      input logic [31:0] step);
    logic [31:0] a;
    logic [31:0] v;
    for (int k = 0; k < n; k++) begin
      a = base + 32'(k);
      v = first + step * 32'(k);
      mem[a] = v;
      exp_q.push_back(a);
      exp_ops[k] = v;
    end
  endtask

  // driver: present one instruction for one cycle, leaves time at accept edge + 1
  task automatic issue(input logic [7:0] op, input logic [31:0] base, input logic exp_stall);
    @(negedge clk);
    inst_in      = {24'hABCDEF, op};
    op_base_addr = base;
    inst_valid   = 1'b1;
    #1;
    chk("stall_at_issue", {31'd0, stall}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
    inst_valid   = 1'b0;
    inst_in      = '0;
    op_base_addr = '0;
  endtask

  task automatic expect_pkt(input string tag, input logic [7:0] op, input int n,
                            input logic err, input int lat_exp);
    int lat;
    lat = 1;
    while (!pkt_valid && lat < 60) begin
      chk({tag, "_stall_busy"}, {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, lat_exp);
    chk({tag, "_valid"}, {31'd0, pkt_valid}, 32'd1);
    chk({tag, "_opcode"}, {24'd0, pkt_opcode}, {24'd0, op});
    chk({tag, "_nops"}, {27'd0, pkt_nops}, n);
    chk({tag, "_err"}, {31'd0, pkt_err}, {31'd0, err});
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s_op%0d", tag, k), pkt_ops[k*32 +: 32], exp_ops[k]);
    chk({tag, "_addr_count"}, seen_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < seen_q.size()) chk($sformatf("%s_addr%0d", tag, i), seen_q[i], exp_q[i]);
    end
  endtask

  task automatic consume(input string tag);
    chk({tag, "_stall_out"}, {31'd0, stall}, 32'd1);
    @(negedge clk);
    pkt_ready = 1'b1;
    @(posedge clk);
    #1;
    pkt_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, pkt_valid}, 32'd0);
    chk({tag, "_stall_idle"}, {31'd0, stall}, 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    inst_in      = '0;
    inst_valid   = 1'b0;
    op_base_addr = '0;
    pkt_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_valid", {31'd0, pkt_valid}, 32'd0);
    chk("rst_bram_en", {31'd0, bram_en}, 32'd0);
    chk("rst_nops", {27'd0, pkt_nops}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_ops", {31'd0, |pkt_ops}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // VERTEX, three operands
    prep();
    load(32'h10, 3, 32'd1, 32'd1);
    issue(8'h03, 32'h10, 1'b1);
    expect_pkt("vertex", 8'h03, 3, 1'b0, 4);
    consume("vertex");

    // LOADMATRIX, sixteen operands
    prep();
    load(32'h200, 16, 32'h100, 32'd1);
    issue(8'h13, 32'h200, 1'b1);
    expect_pkt("loadmtx", 8'h13, 16, 1'b0, 17);
    consume("loadmtx");

    // FRUSTUM held by downstream, VIEWPORT waiting at the input
    prep();
    load(32'h300, 6, 32'hA0, 32'd1);
    issue(8'h1A, 32'h300, 1'b1);
    expect_pkt("frustum", 8'h1A, 6, 1'b0, 7);
    seen_q.delete();
    @(negedge clk);
    inst_in      = {24'hABCDEF, 8'h19};
    op_base_addr = 32'h600;
    inst_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, pkt_valid}, 32'd1);
      chk("hold_stall", {31'd0, stall}, 32'd1);
      chk("hold_opcode", {24'd0, pkt_opcode}, 32'h1A);
      chk("hold_op0", pkt_ops[31:0], 32'hA0);
      chk("hold_op5", pkt_ops[5*32 +: 32], 32'hA5);
      chk("hold_bram_en", {31'd0, bram_en}, 32'd0);
    end
    chk("hold_no_reads", seen_q.size(), 0);
    prep();
    load(32'h600, 4, 32'h5000, 32'd1);
    @(negedge clk);
    pkt_ready = 1'b1;
    @(posedge clk);
    #1;
    pkt_ready = 1'b0;
    chk("frustum_valid_drop", {31'd0, pkt_valid}, 32'd0);
    chk("vp_idle_state", {30'd0, dbg_state}, 32'd0);
    chk("vp_idle_stall", {31'd0, stall}, 32'd1);
    chk("vp_idle_bram_en", {31'd0, bram_en}, 32'd1);
    chk("vp_idle_bram_addr", bram_addr, 32'h600);
    @(posedge clk);
    #1;
    inst_valid   = 1'b0;
    inst_in      = '0;
    op_base_addr = '0;
    expect_pkt("viewport", 8'h19, 4, 1'b0, 5);
    consume("viewport");

    // NOP dropped, unknown opcode flagged, known zero-operand opcode
    @(negedge clk);
    inst_in    = {24'hABCDEF, 8'h00};
    inst_valid = 1'b1;
    #1;
    chk("nop_stall", {31'd0, stall}, 32'd0);
    chk("nop_bram_en", {31'd0, bram_en}, 32'd0);
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    chk("nop_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("nop_no_pkt", {31'd0, pkt_valid}, 32'd0);
    prep();
    issue(8'hFF, 32'h700, 1'b1);
    expect_pkt("badop", 8'hFF, 0, 1'b1, 1);
    consume("badop");
    prep();
    issue(8'h02, 32'h700, 1'b1);
    expect_pkt("ctrl02", 8'h02, 0, 1'b0, 1);
    consume("ctrl02");

    // reset in the middle of a MULTMATRIX read, then a clean COLOR
    prep();
    load(32'h400, 16, 32'h900, 32'd1);
    issue(8'h11, 32'h400, 1'b1);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_bram_en", {31'd0, bram_en}, 32'd0);
    chk("mid_rst_bram_addr", bram_addr, 32'd0);
    chk("mid_rst_valid", {31'd0, pkt_valid}, 32'd0);
    chk("mid_rst_nops", {27'd0, pkt_nops}, 32'd0);
    chk("mid_rst_opcode", {24'd0, pkt_opcode}, 32'd0);
    chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    chk("mid_rst_ops", {31'd0, |pkt_ops}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    prep();
    load(32'h500, 3, 32'd7, 32'd1);
    issue(8'h04, 32'h500, 1'b1);
    expect_pkt("color", 8'h04, 3, 1'b0, 4);
    consume("color");

    // operand address wraps past the top of the address space
    prep();
    load(32'hFFFF_FFFE, 4, 32'h11, 32'h11);
    issue(8'h19, 32'hFFFF_FFFE, 1'b1);
    expect_pkt("wrap", 8'h19, 4, 1'b0, 5);
    consume("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
